// File: rtl/ifid_buffer.sv
// ifid_buffer: IF/ID decoupling buffer for the MiniMIPS32 pipeline.
// Pairs each issued fetch address with the instruction word returned one
// cycle later by the synchronous instruction memory. The pairs are queued in
// a DEPTH-entry FIFO and handed to ID over a valid/ready handshake.
//
// Ports:
//   cpu_clk_50M  pipeline clock, rising edge
//   cpu_rst      asynchronous active-high reset
//   ice          IF chip enable (fetch attempted this cycle)
//   iaddr        fetch address presented to instruction memory
//   inst         instruction memory read data (for the previous cycle's fetch)
//   flush        redirect: kills all queued and in-flight fetches
//   id_ready     ID accepts the head entry this cycle
//   if_stall     IF must hold pc/iaddr; no fetch accepted this cycle
//   id_valid     head entry valid
//   id_pc        PC of the head entry
//   id_inst      instruction of the head entry
module ifid_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        ice,
    input  logic [31:0] iaddr,
    input  logic [31:0] inst,
    input  logic        flush,
    input  logic        id_ready,
    output logic        if_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;

    logic            req_valid;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            issue;
    logic            push;
    logic            pop;
    logic [CW:0]     occupancy;

    // Reserve a slot for the in-flight response, so a push never meets a full FIFO.
    // Built from registered state only: no path from id_ready to if_stall.
    assign occupancy = {1'b0, count} + (CW+1)'(req_valid);
    assign if_stall  = occupancy >= (CW+1)'(DEPTH);

    assign id_valid  = (count != '0);
    assign id_pc     = pc_mem[rd_ptr];
    assign id_inst   = inst_mem[rd_ptr];

    assign issue     = ice & ~if_stall & ~flush;
    assign push      = req_valid & ~flush;
    assign pop       = id_valid & id_ready & ~flush;

    // In-flight fetch slot: remembers the address whose data arrives next cycle.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            req_valid <= 1'b0;
            req_pc    <= '0;
        end else begin
            req_valid <= issue;
            if (issue) begin
                req_pc <= iaddr;
            end
        end
    end

    // Pointers and occupancy; flush wipes the queue.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Pair storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= req_pc;
            inst_mem[wr_ptr] <= inst;
        end
    end

endmodule

// File: tb/tb_ifid_buffer.sv
// tb_ifid_buffer: scoreboard bench for ifid_buffer. The stimulus process acts
// as IF plus instruction memory and queues every issued {pc, inst} pair; the
// monitor compares the head of that queue against the DUT on every negedge
// where id_valid is high.
module tb_ifid_buffer;

    localparam logic [31:0] KEY = 32'hFFFF_0000;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } pair_t;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst;
    logic        ice;
    logic [31:0] iaddr;
    logic [31:0] inst;
    logic        flush;
    logic        id_ready;
    logic        if_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int          checks   = 0;
    int          failures = 0;
    pair_t       sb[$];
    logic [31:0] pc;
    logic        prev_issued;
    logic [31:0] prev_addr;

    ifid_buffer #(.DEPTH(4)) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .ice         (ice),
        .iaddr       (iaddr),
        .inst        (inst),
        .flush       (flush),
        .id_ready    (id_ready),
        .if_stall    (if_stall),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One pipeline cycle, entered and left at posedge+1.
    task automatic cycle(input logic ice_v, input logic flush_v, input logic rdy_v);
        logic issued;
        ice      = ice_v;
        flush    = flush_v;
        id_ready = rdy_v;
        iaddr    = pc;
        inst     = prev_issued ? (prev_addr ^ KEY) : BAD;
        issued   = ice_v & ~if_stall & ~flush_v & ~cpu_rst;
        if (flush_v) sb.delete();
        if (issued) sb.push_back({pc, pc ^ KEY});
        @(posedge cpu_clk_50M);
        #1;
        prev_issued = issued;
        prev_addr   = pc;
        if (issued) pc = pc + 32'd4;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1);
        check1("drain_empty_sb", 32'(sb.size()), 32'd0);
        check1("drain_id_valid", 32'(id_valid), 32'd0);
    endtask

    // Scoreboard monitor.
    always @(negedge cpu_clk_50M) begin
        if (!cpu_rst && !flush && id_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mon_unexpected_valid actual id_pc=%h required=no entry", id_pc);
            end else begin
                check1("mon_pc", id_pc, sb[0].pc);
                check1("mon_inst", id_inst, sb[0].inst);
                if (id_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] exp_stall;
        int         issued_n;
        int         guard;

        cpu_rst     = 1'b1;
        ice         = 1'b0;
        flush       = 1'b0;
        id_ready    = 1'b0;
        iaddr       = '0;
        inst        = '0;
        pc          = '0;
        prev_issued = 1'b0;
        prev_addr   = '0;

        // Reset state.
        #1;
        check1("rst_id_valid", 32'(id_valid), 32'd0);
        check1("rst_if_stall", 32'(if_stall), 32'd0);
        check1("rst_id_pc", id_pc, 32'd0);
        check1("rst_id_inst", id_inst, 32'd0);
        repeat (2) @(posedge cpu_clk_50M);
        #1;
        cpu_rst = 1'b0;

        // Streaming with id_ready high: latency 2, no stall.
        pc = 32'h0;
        cycle(1'b1, 1'b0, 1'b1);
        check1("lat_n1_valid", 32'(id_valid), 32'd0);
        cycle(1'b1, 1'b0, 1'b1);
        check1("lat_n2_valid", 32'(id_valid), 32'd1);
        check1("lat_n2_pc", id_pc, 32'h0);
        for (int i = 0; i < 10; i++) begin
            check1("stream_stall", 32'(if_stall), 32'd0);
            cycle(1'b1, 1'b0, 1'b1);
        end
        drain(4);

        // Reset mid-stream with 3 entries queued.
        pc = 32'h200;
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        check1("pre_rst_valid", 32'(id_valid), 32'd1);
        ice     = 1'b0;
        cpu_rst = 1'b1;
        #1;
        check1("mid_rst_id_valid", 32'(id_valid), 32'd0);
        check1("mid_rst_if_stall", 32'(if_stall), 32'd0);
        check1("mid_rst_id_pc", id_pc, 32'd0);
        check1("mid_rst_id_inst", id_inst, 32'd0);
        sb.delete();
        prev_issued = 1'b0;
        @(posedge cpu_clk_50M);
        @(posedge cpu_clk_50M);
        #1;
        cpu_rst = 1'b0;

        // Back-pressure: 6 cycles with id_ready low from pc 0x0.
        pc        = 32'h0;
        exp_stall = 6'b110000;
        for (int k = 0; k < 6; k++) begin
            check1("bp_stall", 32'(if_stall), 32'(exp_stall[k]));
            if (k == 1) check1("bp_lat_valid_n1", 32'(id_valid), 32'd0);
            if (k == 2) begin
                check1("bp_lat_valid_n2", 32'(id_valid), 32'd1);
                check1("bp_lat_pc_n2", id_pc, 32'h0);
            end
            cycle(1'b1, 1'b0, 1'b0);
        end
        check1("bp_head_pc", id_pc, 32'h0);
        check1("bp_held_entries", 32'(sb.size()), 32'd4);
        repeat (8) cycle(1'b1, 1'b0, 1'b1);
        drain(4);

        // Flush with two queued entries and one response in flight.
        pc = 32'h300;
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        check1("pre_flush_valid", 32'(id_valid), 32'd1);
        cycle(1'b1, 1'b1, 1'b0);
        pc = 32'h100;
        check1("flush_id_valid", 32'(id_valid), 32'd0);
        check1("flush_if_stall", 32'(if_stall), 32'd0);
        cycle(1'b1, 1'b0, 1'b1);
        check1("post_flush_n1_valid", 32'(id_valid), 32'd0);
        cycle(1'b1, 1'b0, 1'b1);
        check1("post_flush_n2_valid", 32'(id_valid), 32'd1);
        check1("post_flush_first_pc", id_pc, 32'h100);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        drain(4);

        // Simultaneous push and pop at count 3.
        pc = 32'h400;
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        check1("pp_stall_full", 32'(if_stall), 32'd1);
        cycle(1'b1, 1'b0, 1'b1);
        check1("pp_stall_after", 32'(if_stall), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        check1("pp_stall_refill", 32'(if_stall), 32'd1);
        drain(8);

        // Wrap-around: 20 issues with random id_ready.
        pc       = 32'h500;
        issued_n = 0;
        guard    = 0;
        while (issued_n < 20 && guard < 300) begin
            cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            if (prev_issued) issued_n++;
            guard++;
        end
        check1("wrap_issued", 32'(issued_n), 32'd20);
        check1("wrap_last_pc", pc, 32'h550);
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifid_buffer.md
# ifid_buffer

Decoupling buffer between the instruction-fetch stage and the decode stage of the MiniMIPS32 pipeline. It pairs each fetch address issued by IF with the instruction word returned one cycle later by the synchronous instruction memory, and queues the pairs in a small FIFO. It presents them to ID with a valid/ready handshake, back-pressures IF through `if_stall`, and discards wrong-path work on `flush`.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2; DEPTH ≥ 4 sustains one instruction per cycle.
- `cpu_clk_50M`  input  1  pipeline clock; all state updates on its rising edge.
- `cpu_rst`  input  1  reset; asynchronous, active-high.
- `ice`  input  1  IF chip enable; a fetch is attempted this cycle when high.
- `iaddr`  input  32  fetch address presented to instruction memory this cycle.
- `inst`  input  32  instruction memory read data; valid in the cycle after the fetch issued.
- `flush`  input  1  redirect from ID/EXE (jump/branch taken); kills all queued and in-flight fetches.
- `id_ready`  input  1  ID accepts the head entry this cycle.
- `if_stall`  output  1  IF must hold `pc`/`iaddr`; no fetch is accepted this cycle.
- `id_valid`  output  1  head entry valid.
- `id_pc`  output  32  PC of the head entry.
- `id_inst`  output  32  instruction of the head entry.

## Operation
- Internal state: `req_valid`/`req_pc` (one in-flight fetch slot), FIFO storage `pc_mem[DEPTH]`/`inst_mem[DEPTH]`, `rd_ptr`, `wr_ptr` (log2(DEPTH) bits, wrap naturally), `count` (log2(DEPTH)+1 bits).
- Issue: `issue = ice & ~if_stall & ~flush`. On issue, `req_valid<=1`, `req_pc<=iaddr`. Otherwise `req_valid<=0`.
- Response/push: when `req_valid=1` and `flush=0`, write `{req_pc, inst}` at `wr_ptr` and increment `wr_ptr`.
- Pop: `pop = id_valid & id_ready & ~flush`; increment `rd_ptr`.
- `count` next = count + push − pop. Push and pop in the same cycle leave `count` unchanged, including when `count = DEPTH−1`.
- `if_stall = (count + req_valid) >= DEPTH`. This is a function of registered state only and has no combinational path from `id_ready`. It guarantees every in-flight response has a free entry, so a push into a full FIFO cannot occur.
- `id_valid = (count != 0)`; `id_pc`/`id_inst` = entry at `rd_ptr`, read combinationally.
- Flush, highest priority: `count<=0`, `rd_ptr<=0`, `wr_ptr<=0`, `req_valid<=0`. The `inst` arriving in the flush cycle is dropped, and `iaddr` presented in the flush cycle is not issued. After flush, `if_stall=0` and `id_valid=0` in the next cycle.
- Storage contents need no reset. The outputs are qualified by `id_valid`, except the reset values below.

## Timing
- Reset (async, immediate): `count=0`, pointers 0, `req_valid=0`, `req_pc=0`, `id_valid=0`, `if_stall=0`, `id_pc=0`, `id_inst=0`. Entry 0 is cleared so the head reads 0.
- Latency: fetch issued in cycle N → `inst` sampled at end of N+1 → `id_valid=1` with that pair in N+2, if the FIFO was empty.
- Throughput: with `DEPTH=4` and `id_ready` held high, one instruction per cycle and `if_stall` never asserts.
- `id_ready` low for k cycles with `ice` high: the FIFO fills. `if_stall` rises when `count + req_valid` reaches DEPTH. No entry is lost or duplicated.
- `id_pc`/`id_inst` stay stable while `id_valid=1` and `id_ready=0`.
- `ice=0`: no issue, no stall side-effect; the pending `req_valid` response is still pushed.
- Reset mid-operation discards everything. The first `id_valid` after release is at least 2 cycles after the first issue.

## Test plan
- Reset: assert `cpu_rst` mid-stream with 3 entries queued → all outputs 0 immediately; after release, fetches at 0x0, 0x4 appear on `id_pc` in order from cycle 2.
- Streaming: `ice=1`, `iaddr` 0x0,0x4,0x8,…, `inst`=addr^0xFFFF0000 one cycle later, `id_ready=1` → `id_valid` from cycle 2, pairs match, `if_stall` never high.
- Back-pressure: stream with `id_ready=0` for 6 cycles → `if_stall` high once count+req_valid=4. Exactly 4 entries are held (0x0–0xC), `id_pc`=0x0 stable. Releasing `id_ready` drains 0x0..0xC, then 0x10 follows.
- Flush with in-flight: 2 entries queued, req pending, pulse `flush` → next cycle `id_valid=0`, `if_stall=0`. The pending `inst` is not queued. The next issued address (e.g. 0x100) is the first output.
- Simultaneous push/pop at count=3: `id_ready=1` with a response arriving → count stays 3, order preserved.
- Wrap-around: stream 20 instructions with random `id_ready` → pointers wrap; output sequence is identical to the issue sequence with no gaps.
